sem_arbiter: RTL and testbench

Hardware semaphore controller for the RTOS IP set. It shares a bank of counting semaphores between N_REQ requesters, such as cores or hardware task slots. Requests are arbitrated round-robin and executed atomically. Blocking TAKEs are parked and released directly by a later GIVE. It sits behind the semaphore AXI-Lite front-end, which drives one requester port per bus master.

---
 rtl/sem_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 35 +++
 rtl/sem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sem_arb_pkg.sv
// Shared types for the hardware semaphore arbiter: operation codes,
// response status codes, FSM states and a small index helper.
package sem_arb_pkg;

    typedef enum logic {
        OP_TAKE = 1'b0,
        OP_GIVE = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK          = 2'b00,
        ST_WOULD_BLOCK = 2'b01,
        ST_OVERFLOW    = 2'b10,
        ST_BAD_ID      = 2'b11
    } status_e;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    // Successor of a round-robin index, wrapping at n.
    function automatic int next_idx(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: grants the first set bit of mask at or after ptr,
// wrapping around to bit 0. Purely combinational.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Two passes: the upper segment [ptr..N-1] first, then the wrapped segment.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!any && mask[j] && (j >= int'(ptr))) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!any && mask[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sem_arbiter.sv
// Hardware semaphore controller: a bank of counting semaphores shared by
// N_REQ requesters. One request is accepted per two cycles (IDLE picks a
// winner round-robin, EXEC performs the operation atomically). Blocking
// TAKEs park the requester until a GIVE on the same semaphore hands the
// token over directly, answering both parties in the same cycle.
module sem_arbiter
    import sem_arb_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int N_SEM      = 4,
    parameter int SEM_W      = 3,
    parameter int MAX_COUNT  = 3,
    parameter int INIT_COUNT = 1,
    parameter int CNT_W      = $clog2(MAX_COUNT + 1)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_op,
    input  logic [N_REQ-1:0]         req_nb,
    input  logic [N_REQ*SEM_W-1:0]   req_sem,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [2*N_REQ-1:0]       rsp_status,
    output logic [N_SEM*CNT_W-1:0]   sem_count,
    output logic [N_REQ-1:0]         waiting
);

    localparam int IDX_W = $clog2(N_REQ);

    state_e               state, state_nxt;
    logic [N_REQ-1:0]     busy;
    logic [IDX_W-1:0]     rr_ptr, wake_ptr;
    logic [CNT_W-1:0]     cnt [N_SEM];
    logic [SEM_W-1:0]     wait_sem [N_REQ];

    // Arbitration (stage p0: the IDLE cycle)
    logic [N_REQ-1:0]     eligible_p0;
    logic [N_REQ-1:0]     win_oh_p0;
    logic [IDX_W-1:0]     win_idx_p0;
    logic                 win_any_p0;

    // Latched request (stage p1: the EXEC cycle)
    op_e                  op_p1;
    logic                 nb_p1;
    logic [SEM_W-1:0]     sem_p1;
    logic [N_REQ-1:0]     win_p1;

    logic                 bad_id;
    logic [CNT_W-1:0]     cur_cnt;
    logic [N_REQ-1:0]     waiter_mask;
    logic [N_REQ-1:0]     wake_oh;
    logic [IDX_W-1:0]     wake_idx;
    logic                 wake_any;

    logic                 w_rsp;
    status_e              w_status;
    logic                 cnt_up, cnt_dn, park, wake;
    logic [N_REQ-1:0]     rsp_valid_d;
    logic [2*N_REQ-1:0]   rsp_status_d;

    assign eligible_p0 = req_valid & ~busy;

    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_req_pick (
        .mask  (eligible_p0),
        .ptr   (rr_ptr),
        .grant (win_oh_p0),
        .idx   (win_idx_p0),
        .any   (win_any_p0)
    );

    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_wake_pick (
        .mask  (waiter_mask),
        .ptr   (wake_ptr),
        .grant (wake_oh),
        .idx   (wake_idx),
        .any   (wake_any)
    );

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: every accepted request spends exactly one cycle in EXEC
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_any_p0) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: the handshake is the combinational grant while IDLE
    always_comb begin
        req_ready = '0;
        if (state == IDLE) req_ready = win_oh_p0;
    end

    // Latch the winning request's fields at acceptance
    always_ff @(posedge ACLK) begin
        if (state == IDLE && win_any_p0) begin
            win_p1 <= win_oh_p0;
            for (int i = 0; i < N_REQ; i++) begin
                if (win_oh_p0[i]) begin
                    op_p1  <= op_e'(req_op[i]);
                    nb_p1  <= req_nb[i];
                    sem_p1 <= req_sem[i*SEM_W +: SEM_W];
                end
            end
        end
    end

    assign bad_id = (int'(sem_p1) >= N_SEM);

    // Current count of the addressed semaphore and the set of its waiters
    always_comb begin
        cur_cnt     = '0;
        waiter_mask = '0;
        for (int i = 0; i < N_SEM; i++) begin
            if (sem_p1 == SEM_W'(i)) cur_cnt = cnt[i];
        end
        for (int i = 0; i < N_REQ; i++) begin
            waiter_mask[i] = waiting[i] && (wait_sem[i] == sem_p1);
        end
    end

    // Decide the outcome of the latched operation during EXEC
    always_comb begin
        w_rsp    = 1'b0;
        w_status = ST_OK;
        cnt_up   = 1'b0;
        cnt_dn   = 1'b0;
        park     = 1'b0;
        wake     = 1'b0;
        if (state == EXEC) begin
            if (bad_id) begin
                w_rsp    = 1'b1;
                w_status = ST_BAD_ID;
            end else if (op_p1 == OP_TAKE) begin
                if (cur_cnt != '0) begin
                    cnt_dn = 1'b1;
                    w_rsp  = 1'b1;
                end else if (nb_p1) begin
                    w_rsp    = 1'b1;
                    w_status = ST_WOULD_BLOCK;
                end else begin
                    park = 1'b1;
                end
            end else begin
                if (wake_any) begin
                    // Token passes straight to the waiter; count is untouched.
                    wake  = 1'b1;
                    w_rsp = 1'b1;
                end else if (cur_cnt < CNT_W'(MAX_COUNT)) begin
                    cnt_up = 1'b1;
                    w_rsp  = 1'b1;
                end else begin
                    w_rsp    = 1'b1;
                    w_status = ST_OVERFLOW;
                end
            end
        end
    end

    // Assemble per-requester response pulses; woken waiters always get OK
    always_comb begin
        rsp_valid_d  = (w_rsp ? win_p1 : '0) | (wake ? wake_oh : '0);
        rsp_status_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_rsp && win_p1[i]) rsp_status_d[2*i +: 2] = w_status;
        end
    end

    // Stage p2: commit counts, waiter set, pointers and registered responses
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            busy       <= '0;
            waiting    <= '0;
            rr_ptr     <= '0;
            wake_ptr   <= '0;
            rsp_valid  <= '0;
            rsp_status <= '0;
            for (int i = 0; i < N_SEM; i++) cnt[i] <= CNT_W'(INIT_COUNT);
        end else begin
            rsp_valid  <= rsp_valid_d;
            rsp_status <= rsp_status_d;
            busy       <= (busy | req_ready) & ~rsp_valid_d;
            if (park)      waiting <= waiting | win_p1;
            else if (wake) waiting <= waiting & ~wake_oh;
            if (state == IDLE && win_any_p0)
                rr_ptr <= IDX_W'(next_idx(int'(win_idx_p0), N_REQ));
            if (wake)
                wake_ptr <= IDX_W'(next_idx(int'(wake_idx), N_REQ));
            for (int i = 0; i < N_SEM; i++) begin
                if (sem_p1 == SEM_W'(i)) begin
                    if (cnt_up)      cnt[i] <= cnt[i] + CNT_W'(1);
                    else if (cnt_dn) cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    // Remember which semaphore a parked requester is waiting on
    always_ff @(posedge ACLK) begin
        if (park) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (win_p1[i]) wait_sem[i] <= sem_p1;
            end
        end
    end

    // Flatten the count bank onto the output bus
    always_comb begin
        sem_count = '0;
        for (int i = 0; i < N_SEM; i++) sem_count[i*CNT_W +: CNT_W] = cnt[i];
    end

endmodule

// File: tb/tb_sem_arbiter.sv
// Bench for sem_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level semaphore model.
module tb_sem_arbiter;

    localparam int N_REQ     = 4;
    localparam int N_SEM     = 4;
    localparam int SEM_W     = 3;
    localparam int MAX_COUNT = 3;
    localparam int INIT_CNT  = 1;
    localparam int CNT_W     = 2;

    logic                    ACLK;
    logic                    ARESETN;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_op;
    logic [N_REQ-1:0]        req_nb;
    logic [N_REQ*SEM_W-1:0]  req_sem;
    logic [N_REQ-1:0]        rsp_valid;
    logic [2*N_REQ-1:0]      rsp_status;
    logic [N_SEM*CNT_W-1:0]  sem_count;
    logic [N_REQ-1:0]        waiting;

    int vectors;
    int miscompares;

    // Reference model state
    int       cnt_m [N_SEM];
    bit [3:0] wait_m;
    int       wsem_m [N_REQ];
    int       rr_m;
    int       wake_m;
    bit [3:0] exp_v;
    bit [7:0] exp_s;

    sem_arbiter #(
        .N_REQ(N_REQ), .N_SEM(N_SEM), .SEM_W(SEM_W),
        .MAX_COUNT(MAX_COUNT), .INIT_COUNT(INIT_CNT)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_nb     (req_nb),
        .req_sem    (req_sem),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .sem_count  (sem_count),
        .waiting    (waiting)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N_SEM; i++) cnt_m[i] = INIT_CNT;
        for (int i = 0; i < N_REQ; i++) wsem_m[i] = 0;
        wait_m = '0;
        rr_m   = 0;
        wake_m = 0;
    endfunction

    function automatic int model_pick(input bit [3:0] mask);
        for (int k = 0; k < N_REQ; k++) begin
            if (mask[(rr_m + k) % N_REQ]) return (rr_m + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic bit [7:0] cnt_packed();
        bit [7:0] r;
        r = '0;
        for (int i = 0; i < N_SEM; i++) r[2*i +: 2] = 2'(cnt_m[i]);
        return r;
    endfunction

    // Semantics of one accepted operation by requester w
    function automatic void model_exec(input int w, input bit op, input bit nb, input int s);
        int v;
        exp_v = '0;
        exp_s = '0;
        if (s >= N_SEM) begin
            exp_v[w] = 1'b1; exp_s[2*w +: 2] = 2'b11;
        end else if (op == 1'b0) begin
            if (cnt_m[s] > 0) begin
                cnt_m[s]--; exp_v[w] = 1'b1;
            end else if (nb) begin
                exp_v[w] = 1'b1; exp_s[2*w +: 2] = 2'b01;
            end else begin
                wait_m[w] = 1'b1; wsem_m[w] = s;
            end
        end else begin
            v = -1;
            for (int k = 0; k < N_REQ; k++) begin
                if (v < 0 && wait_m[(wake_m + k) % N_REQ] && wsem_m[(wake_m + k) % N_REQ] == s)
                    v = (wake_m + k) % N_REQ;
            end
            if (v >= 0) begin
                wait_m[v] = 1'b0; exp_v[w] = 1'b1; exp_v[v] = 1'b1;
                wake_m = (v + 1) % N_REQ;
            end else if (cnt_m[s] < MAX_COUNT) begin
                cnt_m[s]++; exp_v[w] = 1'b1;
            end else begin
                exp_v[w] = 1'b1; exp_s[2*w +: 2] = 2'b10;
            end
        end
    endfunction

    task automatic do_reset();
        ARESETN   = 1'b0;
        req_valid = '0; req_op = '0; req_nb = '0; req_sem = '0;
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1;
        model_reset();
    endtask

    // Present a request set, check the grant, then check the response at T+2
    task automatic issue(input bit [3:0] mask, input bit [3:0] ops, input bit [3:0] nbs,
                         input bit [11:0] sems);
        int w;
        @(negedge ACLK);
        req_valid = mask; req_op = ops; req_nb = nbs; req_sem = sems;
        #1;
        w = model_pick(mask & ~wait_m);
        chk("req_ready_T", req_ready, (w >= 0) ? (32'd1 << w) : 32'd0);
        if (w < 0) begin
            req_valid = '0;
            return;
        end
        rr_m = (w + 1) % N_REQ;
        model_exec(w, ops[w], nbs[w], int'(sems[w*3 +: 3]));
        @(negedge ACLK);
        req_valid = '0;
        #1;
        chk("rsp_valid_T1", rsp_valid, 0);
        chk("req_ready_T1", req_ready, 0);
        @(negedge ACLK);
        #1;
        chk("rsp_valid_T2", rsp_valid, exp_v);
        chk("rsp_status_T2", rsp_status, exp_s);
        chk("sem_count_T2", sem_count, cnt_packed());
        chk("waiting_T2", waiting, wait_m);
    endtask

    function automatic bit [11:0] one_sem(input int r, input int s);
        bit [11:0] v;
        v = '0;
        v[r*3 +: 3] = 3'(s);
        return v;
    endfunction

    initial begin
        bit [3:0]  ev [10];
        bit [7:0]  es [10];
        bit [3:0]  mask, ops, nbs, free;
        bit [11:0] sems;
        int        r;

        vectors = 0;
        miscompares = 0;
        do_reset();

        // Reset state
        @(negedge ACLK); #1;
        chk("reset_count", sem_count, 8'h55);
        chk("reset_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_status", rsp_status, 0);
        chk("reset_waiting", waiting, 0);

        // TAKE, park, GIVE-with-waiter
        issue(4'b0001, 4'b0000, 4'b0000, one_sem(0, 2));
        chk("take_count2", sem_count[5:4], 0);
        issue(4'b0010, 4'b0000, 4'b0000, one_sem(1, 2));
        chk("park_waiting", waiting, 4'b0010);
        issue(4'b0001, 4'b0001, 4'b0000, one_sem(0, 2));
        chk("wake_both", rsp_valid, 4'b0011);

        // WOULD_BLOCK and OVERFLOW
        issue(4'b0100, 4'b0000, 4'b0100, one_sem(2, 2));
        chk("wouldblock", rsp_status[5:4], 2'b01);
        for (int k = 0; k < 3; k++) issue(4'b1000, 4'b1000, 4'b0000, one_sem(3, 3));
        chk("overflow", rsp_status[7:6], 2'b10);
        chk("count3_sat", sem_count[7:6], 3);

        // Bad id
        issue(4'b1000, 4'b0000, 4'b0000, one_sem(3, 5));
        chk("bad_id", rsp_status[7:6], 2'b11);

        // All four requesting from reset: accepted 0,1,2,3 every other cycle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge ACLK);
            if (c == 0) begin
                req_valid = 4'hF; req_op = 4'hF; req_nb = '0; req_sem = '0;
            end else if (c % 2 == 1 && c <= 7) begin
                req_valid[(c - 1) / 2] = 1'b0;
            end
            #1;
            chk("rr_ready", req_ready, (c % 2 == 0 && c < 8) ? (32'd1 << (c / 2)) : 32'd0);
            if (c % 2 == 0 && c < 8) begin
                rr_m = (c / 2 + 1) % N_REQ;
                model_exec(c / 2, 1'b1, 1'b0, 0);
                ev[c] = exp_v; es[c] = exp_s;
            end
            if (c >= 2 && c % 2 == 0) begin
                chk("rr_rsp_valid", rsp_valid, ev[c - 2]);
                chk("rr_rsp_status", rsp_status, es[c - 2]);
            end else begin
                chk("rr_rsp_idle", rsp_valid, 0);
            end
        end
        chk("rr_count", sem_count, cnt_packed());

        // Reset while a requester is parked
        do_reset();
        issue(4'b0001, 4'b0000, 4'b0000, one_sem(0, 2));
        issue(4'b0010, 4'b0000, 4'b0000, one_sem(1, 2));
        @(negedge ACLK);
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_waiting", waiting, 0);
        chk("rst_count", sem_count, 8'h55);
        chk("rst_rsp_valid", rsp_valid, 0);
        model_reset();
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK); #1;
            chk("rst_no_rsp", rsp_valid, 0);
        end

        // Random traffic
        do_reset();
        for (int n = 0; n < 80; n++) begin
            free = ~wait_m;
            r = $urandom_range(0, N_REQ - 1);
            while (!free[r]) r = (r + 1) % N_REQ;
            mask = (4'($urandom) & free) | (4'b1 << r);
            ops  = 4'($urandom);
            nbs  = ($countones(free) <= 1) ? 4'hF : 4'($urandom);
            sems = '0;
            for (int i = 0; i < N_REQ; i++)
                sems[i*3 +: 3] = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 3))
                                                           : 3'($urandom_range(4, 7));
            issue(mask, ops, nbs, sems);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
